// File: rtl/cdr_lock_det_if.sv
// Status/stimulus bundle between the PFD-side driver and the CDR lock detector.
interface cdr_lock_det_if #(
  parameter int WIN = 64
) ();
  localparam int ERR_W = $clog2(WIN + 1);

  logic             en;
  logic             up;
  logic             down;
  logic             lock;
  logic             lock_lost;
  logic             win_done;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, up, down,
    input  lock, lock_lost, win_done, err_cnt
  );

  modport slave (
    input  en, up, down,
    output lock, lock_lost, win_done, err_cnt
  );
endinterface

// File: rtl/cdr_lock_det.sv
// CDR lock detector: windowed count of PFD up^down activity, lock after LOCK_CNT quiet windows.
// Define CDR_LOCK_HYST_EN to tolerate one isolated bad window while locked.
module cdr_lock_det #(
  parameter int WIN      = 64,
  parameter int THRESH   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic               refclk,
  input  logic               rst,
  cdr_lock_det_if.slave      det
);
  localparam int WIN_W  = $clog2(WIN);
  localparam int ERR_W  = $clog2(WIN + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t             state_q, state_d;
  logic               up_meta_q, up_s_q, dn_meta_q, dn_s_q;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]   acc_q, acc_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic               close_q, close_d;
  logic               win_good_q, win_good_d;
  logic               lock_q, lock_d;
  logic               lock_lost_q, lock_lost_d;
  logic               win_done_q, win_done_d;
`ifdef CDR_LOCK_HYST_EN
  logic               strike_q, strike_d;
`endif

  logic               act;
  logic               last;
  logic [ERR_W-1:0]   sum;

  // Both PFD outputs high is the reset overlap, not a correction.
  assign act  = up_s_q ^ dn_s_q;
  assign sum  = acc_q + ERR_W'(act);
  assign last = (win_cnt_q == WIN_W'(WIN - 1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      up_meta_q   <= 1'b0;
      up_s_q      <= 1'b0;
      dn_meta_q   <= 1'b0;
      dn_s_q      <= 1'b0;
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      close_q     <= 1'b0;
      win_good_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_lost_q <= 1'b0;
      win_done_q  <= 1'b0;
`ifdef CDR_LOCK_HYST_EN
      strike_q    <= 1'b0;
`endif
    end else begin
      up_meta_q   <= det.up;
      up_s_q      <= up_meta_q;
      dn_meta_q   <= det.down;
      dn_s_q      <= dn_meta_q;
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      close_q     <= close_d;
      win_good_q  <= win_good_d;
      lock_q      <= lock_d;
      lock_lost_q <= lock_lost_d;
      win_done_q  <= win_done_d;
`ifdef CDR_LOCK_HYST_EN
      strike_q    <= strike_d;
`endif
    end
  end

  // The verdict on a closed window is acted on one edge later, so win_done,
  // lock and lock_lost all move together on the edge after the closing cycle.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    close_d     = 1'b0;
    win_good_d  = win_good_q;
    lock_lost_d = 1'b0;
    win_done_d  = 1'b0;
`ifdef CDR_LOCK_HYST_EN
    strike_d    = strike_q;
`endif
    case (state_q)
      IDLE: begin
        win_cnt_d  = '0;
        acc_d      = '0;
        good_cnt_d = '0;
`ifdef CDR_LOCK_HYST_EN
        strike_d   = 1'b0;
`endif
        if (det.en) state_d = ACQ;
      end
      default: begin
        if (last) err_cnt_d = sum;
        if (!det.en) begin
          state_d    = IDLE;
          win_cnt_d  = '0;
          acc_d      = '0;
          good_cnt_d = '0;
`ifdef CDR_LOCK_HYST_EN
          strike_d   = 1'b0;
`endif
        end else begin
          if (last) begin
            win_cnt_d  = '0;
            acc_d      = '0;
            close_d    = 1'b1;
            win_good_d = (int'(sum) <= THRESH);
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            acc_d      = sum;
          end
          if (close_q) begin
            win_done_d = 1'b1;
            if (state_q == ACQ) begin
              if (!win_good_q) begin
                good_cnt_d = '0;
              end else if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                state_d    = LOCKED;
                good_cnt_d = '0;
`ifdef CDR_LOCK_HYST_EN
                strike_d   = 1'b0;
`endif
              end else begin
                good_cnt_d = good_cnt_q + GOOD_W'(1);
              end
            end else begin
`ifdef CDR_LOCK_HYST_EN
              if (win_good_q) begin
                strike_d = 1'b0;
              end else if (!strike_q) begin
                strike_d = 1'b1;
              end else begin
                state_d     = ACQ;
                lock_lost_d = 1'b1;
                good_cnt_d  = '0;
                strike_d    = 1'b0;
              end
`else
              if (!win_good_q) begin
                state_d     = ACQ;
                lock_lost_d = 1'b1;
                good_cnt_d  = '0;
              end
`endif
            end
          end
        end
      end
    endcase
    lock_d = (state_d == LOCKED);
  end

  assign det.lock      = lock_q;
  assign det.lock_lost = lock_lost_q;
  assign det.win_done  = win_done_q;
  assign det.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_cdr_lock_det.sv
// Randomized bench for cdr_lock_det against a window-level behavioural model.
module tb_cdr_lock_det;
  localparam int WIN      = 64;
  localparam int THRESH   = 4;
  localparam int LOCK_CNT = 8;

  logic refclk = 1'b0;
  logic rst;
  always #5 refclk = ~refclk;

  cdr_lock_det_if #(.WIN(WIN)) dif ();

  cdr_lock_det #(.WIN(WIN), .THRESH(THRESH), .LOCK_CNT(LOCK_CNT)) dut (
    .refclk (refclk),
    .rst    (rst),
    .det    (dif)
  );

  int errors = 0;
  int checks = 0;

  // Model state: synchronizer delay line, window position and lock bookkeeping.
  bit hist[$];
  bit m_active, m_lock, m_strike, m_pend, m_pend_good;
  int m_j, m_acc, m_run, exp_err;
  bit exp_wd, exp_lost;
  int edge_n = 0;
  int en_edge = 0;
  int lock_edge = -1;
  int lost_pulses = 0;
  bit prev_lock = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    m_active = 0; m_lock = 0; m_strike = 0; m_pend = 0; m_pend_good = 0;
    m_j = 0; m_acc = 0; m_run = 0; exp_err = 0;
  endtask

  task automatic judge(input bit good);
    if (!m_lock) begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == LOCK_CNT) begin
        m_lock = 1; m_run = 0; m_strike = 0;
      end
    end else if (good) begin
      m_strike = 0;
    end else begin
`ifdef CDR_LOCK_HYST_EN
      if (!m_strike) m_strike = 1;
      else begin m_lock = 0; exp_lost = 1; m_run = 0; m_strike = 0; end
`else
      m_lock = 0; exp_lost = 1; m_run = 0;
`endif
    end
  endtask

  task automatic step();
    bit x, en_s, act, closed, cgood;
    int s;
    x = dif.up ^ dif.down;
    en_s = dif.en;
    closed = 0; cgood = 0;
    @(posedge refclk);
    #1;
    edge_n++;
    exp_wd = 0; exp_lost = 0;
    if (rst) begin
      model_reset();
    end else begin
      hist.push_back(x);
      act = hist.pop_front();
      if (!m_active) begin
        if (en_s) begin m_active = 1; m_j = 0; m_acc = 0; end
      end else if (!en_s) begin
        if (m_j == WIN - 1) exp_err = m_acc + int'(act);
        m_active = 0; m_lock = 0; m_run = 0; m_strike = 0; m_pend = 0;
        m_j = 0; m_acc = 0;
      end else begin
        s = m_acc + int'(act);
        if (m_j == WIN - 1) begin
          exp_err = s; cgood = (s <= THRESH); closed = 1; m_acc = 0; m_j = 0;
        end else begin
          m_acc = s; m_j++;
        end
        if (m_pend) begin exp_wd = 1; judge(m_pend_good); end
        m_pend = closed; m_pend_good = cgood;
      end
    end
    check_eq("lock", dif.lock, m_lock);
    check_eq("lock_lost", dif.lock_lost, exp_lost);
    check_eq("win_done", dif.win_done, exp_wd);
    check_eq("err_cnt", dif.err_cnt, exp_err);
    if (dif.lock && !prev_lock && lock_edge < 0) lock_edge = edge_n;
    prev_lock = dif.lock;
    if (dif.lock_lost) lost_pulses++;
  endtask

  // One window of stimulus; activity is kept off the last two cycles so the
  // synchronizer delay lands every sample inside the same window.
  task automatic drive_win(input int npulse, input int hold_dn, input int hold_ov);
    bit pu[WIN];
    bit pd[WIN];
    int p, s;
    for (int i = 0; i < WIN; i++) begin pu[i] = 0; pd[i] = 0; end
    for (int k = 0; k < npulse; k++) begin
      do p = $urandom_range(WIN - 3, 0); while (pu[p]);
      pu[p] = 1;
    end
    if (hold_dn > 0) begin
      s = $urandom_range(WIN - 2 - hold_dn, 0);
      for (int i = 0; i < hold_dn; i++) pd[s + i] = 1;
    end
    if (hold_ov > 0) begin
      s = $urandom_range(WIN - 2 - hold_ov, 0);
      for (int i = 0; i < hold_ov; i++) begin pu[s + i] = 1; pd[s + i] = 1; end
    end
    for (int j = 0; j < WIN; j++) begin
      dif.up = pu[j]; dif.down = pd[j];
      step();
    end
    dif.up = 0; dif.down = 0;
  endtask

  task automatic start_acq();
    dif.en = 1;
    step();
    en_edge = edge_n;
    lock_edge = -1;
  endtask

  task automatic go_idle(input int n);
    dif.en = 0;
    repeat (n) step();
  endtask

  initial begin
    int l0;
    model_reset();
    rst = 1; dif.en = 0; dif.up = 0; dif.down = 0;
    repeat (8) begin dif.up = 1'($urandom); step(); end
    rst = 0;
    repeat (20) begin dif.up = 1'($urandom); step(); end
    dif.up = 0;
    repeat (3) step();

    // Clean acquire
    start_acq();
    repeat (9) drive_win(0, 0, 0);
    check_eq("clean_lock_lat", lock_edge - en_edge, LOCK_CNT * WIN + 1);

    // Disable mid-window while locked
    l0 = lost_pulses;
    repeat (30) step();
    dif.en = 0;
    step();
    check_eq("dis_lock", dif.lock, 0);
    repeat (5) step();
    check_eq("dis_no_lost", lost_pulses - l0, 0);

    // Reacquire at exactly THRESH active samples per window
    start_acq();
    repeat (9) drive_win(THRESH, 0, 0);
    check_eq("thr4_lock_lat", lock_edge - en_edge, LOCK_CNT * WIN + 1);

    // Loss of lock
    l0 = lost_pulses;
    drive_win(0, 20, 0);
    check_eq("lol_err", dif.err_cnt, 20);
`ifdef CDR_LOCK_HYST_EN
    drive_win(0, 20, 0);
    check_eq("hyst_hold_lock", dif.lock, 1);
    check_eq("hyst_no_lost", lost_pulses - l0, 0);
    drive_win(0, 0, 0);
`else
    drive_win(0, 0, 0);
`endif
    check_eq("lol_lock", dif.lock, 0);
    check_eq("lol_pulses", lost_pulses - l0, 1);

    // One over-threshold window in the 7th slot restarts the good run
    go_idle(2);
    start_acq();
    repeat (6) drive_win(THRESH, 0, 0);
    drive_win(THRESH + 1, 0, 0);
    check_eq("thr5_err", dif.err_cnt, THRESH + 1);
    repeat (9) drive_win(0, 0, 0);
    check_eq("thr5_lock_lat", lock_edge - en_edge, 15 * WIN + 1);

    // Overlapping up/down is masked
    go_idle(2);
    start_acq();
    repeat (9) drive_win(0, 0, 10);
    check_eq("ovl_lock_lat", lock_edge - en_edge, LOCK_CNT * WIN + 1);

    // en drops on the closing cycle: err_cnt updates, no win_done
    for (int j = 0; j < WIN; j++) begin
      dif.up = (j == 5 || j == 20 || j == WIN - 3);
      dif.en = (j != WIN - 1);
      step();
    end
    dif.up = 0;
    check_eq("close_drop_err", dif.err_cnt, 3);
    repeat (6) step();
    check_eq("idle_err_hold", dif.err_cnt, 3);

    // Random mixed activity
    start_acq();
    repeat (20) drive_win($urandom_range(2 * THRESH, 0), 0, 0);

    // Reset mid-window discards the partial count
    repeat (25) begin dif.up = 1'($urandom); step(); end
    dif.up = 0;
    rst = 1;
    step();
    check_eq("rst_err", dif.err_cnt, 0);
    rst = 0;
    step();
    en_edge = edge_n;
    lock_edge = -1;
    repeat (9) drive_win(0, 0, 0);
    check_eq("rst_lock_lat", lock_edge - en_edge, LOCK_CNT * WIN + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
